// File: rtl/trace_pkg.sv
// Shared types and default widths for the trace player and its skid FIFO.
package trace_pkg;

  localparam int ADDR_W = 32;
  localparam int IDX_W  = 19;
  localparam int HIT_W  = 21;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } tp_state_t;

  // A window of one still needs a 1-bit counter so the wrap compare stays legal.
  function automatic int win_width(input int window);
    return (window > 1) ? $clog2(window) : 1;
  endfunction

endpackage

// File: rtl/trace_player_if.sv
// Address handshake from the trace player into the cache, plus the cache's hit counter.
interface trace_player_if #(
  parameter int ADDR_W = trace_pkg::ADDR_W,
  parameter int HIT_W  = trace_pkg::HIT_W
);

  logic              cache_valid;
  logic [ADDR_W-1:0] cache_addr;
  logic              cache_ready;
  logic [HIT_W-1:0]  hits;

  modport master (
    output cache_valid,
    output cache_addr,
    input  cache_ready,
    input  hits
  );

  modport slave (
    input  cache_valid,
    input  cache_addr,
    output cache_ready,
    output hits
  );

endinterface

// File: rtl/trace_skid_fifo.sv
// Two-entry fall-through FIFO: data pushed into an empty FIFO is visible at the head
// in the same cycle, so RAM read data reaches the cache without an extra stage.
module trace_skid_fifo #(
  parameter int WIDTH = trace_pkg::ADDR_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic [1:0]       occupancy
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic             bypass;
  logic             do_write;
  logic             do_read;

  // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
  always_comb begin
    head     = '0;
    bypass   = (count == 2'd0);
    empty    = bypass && !push;
    do_read  = pop && !bypass;
    do_write = push && !(pop && bypass);
    if (!empty) head = bypass ? push_data : mem[rd_ptr];
  end

  assign occupancy = count;

  // NOTE: storage has no reset; the count and pointers guard every read, so resetting it buys nothing.
  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_write) wr_ptr <= !wr_ptr;
      if (do_read)  rd_ptr <= !rd_ptr;
      count <= count + {1'b0, do_write} - {1'b0, do_read};
    end
  end

  no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(do_write && !do_read && count == 2'd2));

  no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && empty));

endmodule

// File: rtl/trace_player.sv
// Replays a stored address trace into the cache over valid/ready and samples the
// cache hit counter every WINDOW accepted accesses, with a flush sample at the end.
module trace_player #(
  parameter int ADDR_W = trace_pkg::ADDR_W,
  parameter int IDX_W  = trace_pkg::IDX_W,
  parameter int HIT_W  = trace_pkg::HIT_W,
  parameter int WINDOW = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [IDX_W-1:0]  trace_len,
  output logic              mem_rd,
  output logic [IDX_W-1:0]  mem_addr,
  input  logic [ADDR_W-1:0] mem_data,
  trace_player_if.master    cache,
  output logic              sample_valid,
  output logic [HIT_W-1:0]  sample_hits,
  output logic              busy,
  output logic              done
);

  import trace_pkg::*;

  localparam int               WIN_W    = win_width(WINDOW);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);

  tp_state_t         state;
  tp_state_t         state_next;
  logic [IDX_W-1:0]  len_q;
  logic [IDX_W-1:0]  rd_ptr;
  logic [IDX_W-1:0]  acc_cnt;
  logic [WIN_W-1:0]  win_cnt;
  logic              inflight;

  logic              fifo_empty;
  logic [1:0]        fifo_occ;
  logic [ADDR_W-1:0] fifo_head;

  logic              pop;
  logic              take_start;
  logic              last_accept;
  logic              win_wrap;
  logic              take_sample;
  logic [2:0]        occ_after;

  // Data for a read issued last cycle arrives now and is pushed unconditionally.
  trace_skid_fifo #(
    .WIDTH (ADDR_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight),
    .push_data (mem_data),
    .pop       (pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .occupancy (fifo_occ)
  );

  assign cache.cache_valid = !fifo_empty;
  assign cache.cache_addr  = fifo_head;
  assign mem_addr          = rd_ptr;
  assign busy              = (state == RUN);

  always_comb begin
    pop         = !fifo_empty && cache.cache_ready;
    take_start  = (state == IDLE) && start;
    last_accept = pop && (acc_cnt == len_q - IDX_W'(1));
    win_wrap    = pop && (win_cnt == WIN_LAST);
    take_sample = win_wrap || last_accept;
    // Occupancy after this edge; a new read only lands the cycle after that.
    occ_after   = {1'b0, fifo_occ} + {2'b00, inflight} - {2'b00, pop};
    mem_rd      = (state == RUN) && (rd_ptr < len_q) && (occ_after < 3'd2);
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start && trace_len != '0) state_next = RUN;
      RUN:     if (last_accept) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q        <= '0;
      rd_ptr       <= '0;
      acc_cnt      <= '0;
      win_cnt      <= '0;
      inflight     <= 1'b0;
      done         <= 1'b0;
      sample_valid <= 1'b0;
      sample_hits  <= '0;
    end else begin
      inflight <= mem_rd;
      if (take_start) begin
        len_q   <= trace_len;
        rd_ptr  <= '0;
        acc_cnt <= '0;
        win_cnt <= '0;
      end else begin
        if (mem_rd) rd_ptr <= rd_ptr + IDX_W'(1);
        if (pop) begin
          acc_cnt <= acc_cnt + IDX_W'(1);
          win_cnt <= win_wrap ? '0 : win_cnt + WIN_W'(1);
        end
      end
      // A zero-length start still reports completion, without leaving IDLE.
      done         <= (take_start && trace_len == '0) || last_accept;
      sample_valid <= take_sample;
      if (take_sample) sample_hits <= cache.hits;
    end
  end

  stall_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (cache.cache_valid && !cache.cache_ready) |=> (cache.cache_valid && $stable(cache.cache_addr)));

  done_not_busy: assert property (@(posedge clk) disable iff (!rst_n)
    !(done && busy));

endmodule

// File: tb/tb_trace_player.sv
// Scoreboard bench for trace_player: RAM and cache models, queue-based address and
// window-sample checking from a monitor decoupled from the stimulus.
module tb_trace_player;

  localparam int ADDR_W = 32;
  localparam int IDX_W  = 19;
  localparam int HIT_W  = 21;
  localparam int WIN    = 4;
  localparam int RAM_D  = 256;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [IDX_W-1:0]  trace_len = '0;
  logic              mem_rd;
  logic [IDX_W-1:0]  mem_addr;
  logic [ADDR_W-1:0] mem_data = '0;
  logic              sample_valid;
  logic [HIT_W-1:0]  sample_hits;
  logic              busy;
  logic              done;

  trace_player_if #(.ADDR_W(ADDR_W), .HIT_W(HIT_W)) bus ();

  trace_player #(
    .ADDR_W (ADDR_W),
    .IDX_W  (IDX_W),
    .HIT_W  (HIT_W),
    .WINDOW (WIN)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .trace_len    (trace_len),
    .mem_rd       (mem_rd),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .cache        (bus),
    .sample_valid (sample_valid),
    .sample_hits  (sample_hits),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  logic [ADDR_W-1:0] ram [RAM_D];
  logic [ADDR_W-1:0] exp_addr [$];
  int                cur_len = 0;
  int                ready_mode = 0;
  bit                zero_mode = 1'b0;
  int                acc_m = 0;
  int                samples_seen = 0;

  // Synchronous-read trace RAM; junk on cycles without a read exposes misuse of mem_data.
  always @(posedge clk) begin
    if (mem_rd === 1'b1) begin
      check("mem_rd index inside trace", 64'(mem_addr < IDX_W'(cur_len)), 64'd1);
      mem_data <= ram[mem_addr[7:0]];
    end else begin
      mem_data <= $urandom;
    end
  end

  // Cache side: ready pattern selected by the current test, hits change every cycle.
  initial begin
    int cyc;
    cyc = 0;
    bus.cache_ready = 1'b0;
    bus.hits = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      case (ready_mode)
        0:       bus.cache_ready = 1'b1;
        1:       bus.cache_ready = (cyc % 3 == 0);
        default: bus.cache_ready = 1'($urandom_range(0, 1));
      endcase
      bus.hits = HIT_W'($urandom);
    end
  end

  // Monitor: accepted addresses against the queue; samples and done against the
  // window rule (sample after every WIN-th accept and after the last one).
  initial begin
    bit                exp_sample;
    bit                exp_done;
    bit                stalled;
    logic [HIT_W-1:0]  exp_hits;
    logic [ADDR_W-1:0] held;
    exp_sample = 0;
    exp_done   = 0;
    stalled    = 0;
    exp_hits   = '0;
    held       = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        acc_m      = 0;
        exp_sample = 0;
        exp_done   = 0;
        stalled    = 0;
      end else begin
        check("sample_valid", 64'(sample_valid), 64'(exp_sample));
        if (exp_sample) check("sample_hits", 64'(sample_hits), 64'(exp_hits));
        if (!zero_mode) check("done", 64'(done), 64'(exp_done));
        if (sample_valid) samples_seen++;
        if (stalled) begin
          check("valid held under stall", 64'(bus.cache_valid), 64'd1);
          check("addr held under stall", 64'(bus.cache_addr), 64'(held));
        end
        exp_sample = 0;
        exp_done   = 0;
        if (bus.cache_valid && bus.cache_ready) begin
          if (exp_addr.size() == 0) check("unexpected accept", 64'(bus.cache_addr), 64'hDEAD);
          else check("cache_addr", 64'(bus.cache_addr), 64'(exp_addr.pop_front()));
          acc_m++;
          if (acc_m % WIN == 0 || acc_m == cur_len) begin
            exp_sample = 1;
            exp_hits   = bus.hits;
          end
          if (acc_m == cur_len) begin
            exp_done = 1;
            acc_m    = 0;
          end
        end
        stalled = bus.cache_valid && !bus.cache_ready;
        held    = bus.cache_addr;
      end
    end
  end

  task automatic outputs_zero(input string tag);
    check({tag, " busy"}, 64'(busy), 64'd0);
    check({tag, " done"}, 64'(done), 64'd0);
    check({tag, " mem_rd"}, 64'(mem_rd), 64'd0);
    check({tag, " mem_addr"}, 64'(mem_addr), 64'd0);
    check({tag, " cache_valid"}, 64'(bus.cache_valid), 64'd0);
    check({tag, " cache_addr"}, 64'(bus.cache_addr), 64'd0);
    check({tag, " sample_valid"}, 64'(sample_valid), 64'd0);
    check({tag, " sample_hits"}, 64'(sample_hits), 64'd0);
  endtask

  task automatic issue_start(input int len, input int mode);
    @(posedge clk);
    #1;
    cur_len    = len;
    ready_mode = mode;
    for (int i = 0; i < len; i++) exp_addr.push_back(ram[i]);
    start     = 1'b1;
    trace_len = IDX_W'(len);
    @(posedge clk);
    #1;
    start     = 1'b0;
    trace_len = IDX_W'($urandom_range(1, 50));
  endtask

  task automatic run_trace(input int len, input int mode, input bit glitch);
    int n;
    int s0;
    bit seen;
    s0 = samples_seen;
    issue_start(len, mode);
    @(negedge clk);
    check("start busy", 64'(busy), 64'd1);
    check("start mem_rd", 64'(mem_rd), 64'd1);
    check("start mem_addr", 64'(mem_addr), 64'd0);
    @(negedge clk);
    check("start cache_valid", 64'(bus.cache_valid), 64'd1);
    n    = 2;
    seen = 0;
    while (!seen && n < 40 * len + 40) begin
      @(posedge clk);
      #1;
      if (glitch && n == 4) begin
        start     = 1'b1;
        trace_len = IDX_W'(3);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
      if (done) seen = 1;
    end
    check("done within bound", 64'(seen), 64'd1);
    if (mode == 0) check("done latency", 64'(n), 64'(len + 2));
    check("busy low with done", 64'(busy), 64'd0);
    repeat (2) @(negedge clk);
    #1;
    check("all addresses accepted", 64'(exp_addr.size()), 64'd0);
    check("sample count", 64'(samples_seen - s0), 64'((len + WIN - 1) / WIN));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < RAM_D; i++) ram[i] = $urandom;

    repeat (3) @(posedge clk);
    #1;
    outputs_zero("reset");
    rst_n = 1'b1;

    // Basic playback with known addresses and ready tied high.
    for (int i = 0; i < 5; i++) ram[i] = 32'h1000 + 32'(4 * i);
    run_trace(5, 0, 1'b0);

    for (int i = 0; i < RAM_D; i++) ram[i] = $urandom;
    run_trace(10, 1, 1'b0);
    run_trace(10, 0, 1'b0);
    run_trace(8, 0, 1'b0);

    // Zero-length trace: done only, no reads, no cache traffic.
    zero_mode = 1'b1;
    @(posedge clk);
    #1;
    cur_len   = 0;
    start     = 1'b1;
    trace_len = '0;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("zero done", 64'(done), 64'd1);
    check("zero busy", 64'(busy), 64'd0);
    check("zero mem_rd", 64'(mem_rd), 64'd0);
    check("zero cache_valid", 64'(bus.cache_valid), 64'd0);
    repeat (3) begin
      @(negedge clk);
      check("zero done after pulse", 64'(done), 64'd0);
      check("zero mem_rd after", 64'(mem_rd), 64'd0);
      check("zero cache_valid after", 64'(bus.cache_valid), 64'd0);
    end
    zero_mode = 1'b0;

    // Start pulsed mid-run with a different length must not disturb playback.
    run_trace(12, 2, 1'b1);

    // Reset after three accepts, then replay from index 0.
    issue_start(10, 0);
    n = 0;
    while (acc_m < 3 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("reached 3 accepts", 64'(acc_m >= 3), 64'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    outputs_zero("mid-run reset");
    exp_addr.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_trace(6, 0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < RAM_D; i++) ram[i] = $urandom;
      run_trace($urandom_range(1, 40), $urandom_range(0, 2), 1'b0);
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
